// File: rtl/dmem_responder.sv
// Word-addressed data RAM responder: one request in flight, response LATENCY+1 cycles after accept.
// Backpressure only on the request side (req_ready low while busy); responses cannot be stalled.
module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int         AW       = $clog2(DEPTH);
    localparam bit         ZERO_LAT = (LATENCY == 0);
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q;
    logic [31:0]   addr_q, wdata_q;
    logic [3:0]    be_q;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q, rsp_err_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;

    logic [31:0]   mem [DEPTH];

    logic          accept, go_resp, fault, wr_en;
    logic          cur_we;
    logic [31:0]   cur_addr, cur_wdata;
    logic [3:0]    cur_be;
    logic [AW-1:0] idx;

    assign accept = req_valid && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        go_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (ZERO_LAT) begin
                        state_d = RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With zero latency the RESP-entry edge is the accept edge, so use the live request.
    assign cur_we    = (state_q == IDLE) ? req_we    : we_q;
    assign cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    assign cur_be    = (state_q == IDLE) ? req_be    : be_q;

    assign fault = (cur_addr[1:0] != 2'b00) || (cur_addr[31:AW+2] != '0);
    assign idx   = cur_addr[AW+1:2];
    assign wr_en = go_resp && cur_we && !fault;

    always_comb begin
        rsp_valid_d = go_resp;
        rsp_err_d   = go_resp && fault;
        rsp_rdata_d = '0;
        if (go_resp && !cur_we && !fault) begin
            rsp_rdata_d = mem[idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
        end
    end

    // RAM has no reset; contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_be[b]) begin
                    mem[idx][8*b +: 8] <= cur_wdata[8*b +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder on the CPU load/store interface: accepts one word-addressed read or write request at a time and serves it from an internal RAM after a programmable number of wait states. It replaces the single-cycle data memory when the CPU runs with a stalling memory stage. The CPU is the initiator; this block is the responder. Request/response use a valid/ready handshake so the pipeline can stall on `req_ready` and `rsp_valid`.

Parameters:
DEPTH, 64, number of 32-bit words in the RAM (power of two, >= 4)
LATENCY, 2, wait states between request accept and response (0..15)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_we  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_wdata  in  32  store data
req_be  in  4  byte enables for stores (bit i = byte i, little-endian)
req_ready  out  1  responder can accept a request this cycle
rsp_valid  out  1  response present
rsp_rdata  out  32  load data (0 for stores and errors)
rsp_err  out  1  access fault on this response
busy  out  1  request in flight (for stall logic)

Behaviour:
- Reset (reset = 0, async):
  - FSM goes to IDLE.
  - `req_ready` = 1; `rsp_valid`, `rsp_err`, `busy` = 0; `rsp_rdata` = 0; wait counter = 0.
  - RAM contents are not cleared.
- Handshake rules:
  - A request is accepted on a rising edge where `req_valid` and `req_ready` are both 1.
  - A response completes on a rising edge where `rsp_valid` = 1. The initiator must accept it that cycle; there is no response backpressure.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: `req_ready` = 1. On accept, register `we`/`addr`/`wdata`/`be`.
    - LATENCY = 0: go to RESP.
    - LATENCY > 0: go to WAIT with counter = LATENCY-1.
  - WAIT: `req_ready` = 0, `busy` = 1.
    - Counter decrements each cycle.
    - When the counter is 0, go to RESP.
  - RESP: `rsp_valid` = 1 for exactly one cycle, `busy` = 1, `req_ready` = 0. Next state is IDLE.
  - Back-to-back requests: the earliest next accept is the cycle after RESP.
- Latency: accept edge to `rsp_valid` high = LATENCY+1 cycles.
- Address rules:
  - Word index = `req_addr[log2(DEPTH)+1:2]`.
  - Fault if `req_addr[1:0]` != 0, or if `req_addr >> 2` >= DEPTH (upper bits nonzero).
- Store:
  - Bytes with `be` set are written on the RESP-entry edge. Bytes with `be` clear are unchanged.
  - `be` = 0000 is a legal no-op store with `rsp_err` = 0.
  - `rsp_rdata` = 0.
- Load:
  - `rsp_rdata` = full word, read at RESP entry. `req_be` is ignored.
  - A load following a store to the same word returns the new data.
- Fault: no RAM write; `rsp_err` = 1, `rsp_rdata` = 0, timing unchanged.
- Outputs are registered; `rsp_rdata` and `rsp_err` return to 0 when `rsp_valid` = 0.
- Signals outside an accept edge:
  - `req_valid` while `req_ready` = 0 is ignored; the initiator must hold the request.
  - Request inputs are don't-care except on the accept edge.
- Reset asserted mid-operation: the transaction is dropped and no response is issued. A write not yet at the RESP-entry edge does not occur. The FSM restarts in IDLE.

Test Plan:
- Reset: hold reset = 0 for 3 cycles -> `req_ready` = 1, `rsp_valid` = 0, `busy` = 0, `rsp_rdata` = 0.
- LATENCY = 2, store `addr` = 0x10, `wdata` = 0xDEADBEEF, `be` = 1111, then load 0x10 -> each `rsp_valid` arrives exactly 3 cycles after accept; load returns 0xDEADBEEF with `rsp_err` = 0.
- Byte enables: store 0x11223344 to 0x20 with `be` = 1111, then store 0xAABBCCDD with `be` = 0101, then load 0x20 -> 0x11BB33DD.
- Faults: load 0x22 (misaligned), and load `DEPTH`*4 = 0x100 at DEPTH = 64 -> `rsp_err` = 1 and `rsp_rdata` = 0 for both; a store to 0x101 leaves RAM unchanged on re-read.
- LATENCY = 0 with back-to-back requests held on `req_valid` -> one accept every 2 cycles, `rsp_valid` 1 cycle after each accept, `req_ready` low during RESP.
- Reset mid-WAIT: store 0x12345678 to 0x30 (old value 0x0), pull reset low during WAIT -> no `rsp_valid`; after release, load 0x30 returns 0x0.
